key_event_fifo: RTL and testbench

- Memory-mapped, parametrised successor to the single-register key device.
- Samples NKEYS active-low push buttons, synchronises and debounces each one, and queues every debounced state change as an event word in a FIFO_DEPTH-entry FIFO.
- The CPU reads events via DATA and controls status and interrupts via CTRL, on the shared abus/dbus/we bus.
- Raises intr while events are pending and interrupts are enabled.

---
 rtl/key_pkg.sv | 23 ++
 rtl/key_debounce.sv | 41 ++++
 rtl/key_event_fifo.sv | 135 +++++++++++++
 tb/tb_key_event_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants for the key event FIFO: CTRL/event bit positions and default addresses.
package key_pkg;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;
    localparam int COUNT_LSB   = 16;
    localparam int CHG_LSB     = 16;
    localparam int VALID_BIT   = 31;
    localparam int TS_LSB      = 20;
    localparam int TS_BITS     = 11;

    localparam logic [31:0] DATA_ADDR_DEF = 32'hF000_0010;
    localparam logic [31:0] CTRL_ADDR_DEF = 32'hF000_0110;

    // Number of change-mask bits that fit below the timestamp field (or below the valid bit).
    function automatic int chg_width(input int nkeys, input bit ts_en);
        int lim;
        lim = ts_en ? (TS_LSB - CHG_LSB) : (VALID_BIT - CHG_LSB);
        return (nkeys > lim) ? lim : nkeys;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter and debounced pressed state.
// update is a same-cycle strobe: high in the cycle whose edge flips pressed.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic init,
    input  logic key,
    output logic pressed,
    output logic update
);

    logic        s1;
    logic        s2;
    logic        sync_p;
    logic [15:0] cnt;

    assign sync_p = ~s2;
    assign update = (sync_p != pressed) && (cnt == DEBOUNCE_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (init) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            pressed <= 1'b0;
            cnt     <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (sync_p == pressed) begin
                cnt <= '0;
            end else if (update) begin
                pressed <= sync_p;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/key_event_fifo.sv
// Debounced key-change event FIFO with DATA/CTRL bus registers and level interrupt.
// Optional build macro KEY_TIMESTAMP_EN adds a prescaled timestamp to each event word.
module key_event_fifo
    import key_pkg::*;
#(
    parameter int              DBITS           = 32,
    parameter int              NKEYS           = 4,
    parameter int              FIFO_DEPTH      = 8,
    parameter logic [15:0]     DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [DBITS-1:0] DATA_ADDR      = DATA_ADDR_DEF,
    parameter logic [DBITS-1:0] CTRL_ADDR      = CTRL_ADDR_DEF
) (
    input  logic             clk,
    input  logic             init,
    input  logic [NKEYS-1:0] keys,
    input  logic [DBITS-1:0] abus,
    inout  logic [DBITS-1:0] dbus,
    input  logic             we,
    output logic             intr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef KEY_TIMESTAMP_EN
    localparam int CHG_W = chg_width(NKEYS, 1'b1);
`else
    localparam int CHG_W = chg_width(NKEYS, 1'b0);
`endif

    logic [NKEYS-1:0] deb;
    logic [NKEYS-1:0] upd;
    logic [NKEYS-1:0] new_mask;
    logic [DBITS-1:0] ev;
    logic [DBITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             overrun;
    logic             ie;
    logic             rd_data;
    logic             rd_ctrl;
    logic             wr_ctrl;
    logic             ready;
    logic             full;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic [DBITS-1:0] data_word;
    logic [DBITS-1:0] ctrl_word;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .init   (init),
            .key    (keys[g]),
            .pressed(deb[g]),
            .update (upd[g])
        );
    end

`ifdef KEY_TIMESTAMP_EN
    logic [9:0]  pre;
    logic [11:0] ts;

    always_ff @(posedge clk) begin
        if (init) begin
            pre <= '0;
            ts  <= '0;
        end else begin
            pre <= pre + 10'd1;
            if (pre == '1) ts <= ts + 12'd1;
        end
    end
`endif

    assign new_mask = deb ^ upd;
    assign push     = |upd;
    assign rd_data  = !we && (abus == DATA_ADDR);
    assign rd_ctrl  = !we && (abus == CTRL_ADDR);
    assign wr_ctrl  = we && (abus == CTRL_ADDR);
    assign ready    = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = rd_data && ready;
    // A full FIFO still accepts a push when the same edge pops the head.
    assign push_ok  = push && (!full || pop);
    assign intr     = ready && ie;

    always_comb begin
        ev = '0;
        for (int unsigned i = 0; i < NKEYS; i++) ev[i] = new_mask[i];
        for (int unsigned i = 0; i < CHG_W; i++) ev[CHG_LSB + i] = upd[i];
`ifdef KEY_TIMESTAMP_EN
        for (int unsigned i = 0; i < TS_BITS; i++) ev[TS_LSB + i] = ts[i];
`endif
        ev[VALID_BIT] = 1'b1;
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[READY_BIT]   = ready;
        ctrl_word[OVERRUN_BIT] = overrun;
        ctrl_word[IE_BIT]      = ie;
        for (int unsigned i = 0; i < CW; i++) ctrl_word[COUNT_LSB + i] = count[i];
    end

    assign data_word = ready ? mem[rptr] : '0;
    assign dbus = rd_data ? data_word : (rd_ctrl ? ctrl_word : 'z);

    always_ff @(posedge clk) begin
        if (!init && push_ok) mem[wptr] <= ev;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_ctrl) ie <= dbus[IE_BIT];
            // Setting beats a same-cycle software clear.
            if (push && full && !pop)           overrun <= 1'b1;
            else if (wr_ctrl && !dbus[OVERRUN_BIT]) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed self-checking bench for key_event_fifo (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_key_event_fifo;

    localparam logic [31:0] DADDR = 32'hF000_0010;
    localparam logic [31:0] CADDR = 32'hF000_0110;
    localparam logic [31:0] IDLE  = 32'h0000_0000;
    localparam int          DB    = 4;

    logic        clk = 1'b0;
    logic        init;
    logic [3:0]  keys;
    logic [31:0] abus;
    logic        we;
    logic        intr;
    logic        tb_drv;
    logic [31:0] tb_val;
    wire  [31:0] dbus;

    int checks = 0;
    int failures = 0;

    assign dbus = tb_drv ? tb_val : 'z;

    key_event_fifo #(
        .DBITS(32), .NKEYS(4), .FIFO_DEPTH(4), .DEBOUNCE_CYCLES(16'd4),
        .DATA_ADDR(DADDR), .CTRL_ADDR(CADDR)
    ) dut (
        .clk(clk), .init(init), .keys(keys), .abus(abus),
        .dbus(dbus), .we(we), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        abus = addr; we = 1'b0;
        #1 v = dbus;
        abus = IDLE;
    endtask

    task automatic pop_data(output logic [31:0] v);
        abus = DADDR; we = 1'b0;
        #1 v = dbus;
        tick();
        abus = IDLE;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        abus = CADDR; we = 1'b1; tb_drv = 1'b1; tb_val = v;
        tick();
        we = 1'b0; tb_drv = 1'b0; abus = IDLE;
    endtask

    task automatic gen_event(input logic [3:0] k);
        keys = k;
        repeat (DB + 2) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        init = 1'b1; keys = 4'hF;
        tick(); tick();
        init = 1'b0;
        rd(CADDR, v);  chk("reset_ctrl", v, 32'h0);
        rd(DADDR, v);  chk("reset_data", v, 32'h0);
        chk("reset_intr", {31'd0, intr}, 32'h0);
        abus = 32'h1234_0000; tb_drv = 1'b1; tb_val = 32'hA5A5_5A5A;
        #1 v = dbus;
        tb_drv = 1'b0; abus = IDLE;
        chk("reset_bus_released", v, 32'hA5A5_5A5A);
    endtask

    task automatic test_press();
        logic [31:0] v;
        keys = 4'hE;
        repeat (DB + 1) tick();
        rd(CADDR, v);  chk("press_not_yet", v, 32'h0);
        tick();
        rd(CADDR, v);  chk("press_ctrl", v, 32'h0001_0001);
        pop_data(v);   chk("press_data", v, 32'h8001_0001);
        rd(CADDR, v);  chk("press_ctrl_after_pop", v, 32'h0);
        pop_data(v);   chk("empty_pop_data", v, 32'h0);
        rd(CADDR, v);  chk("empty_pop_ctrl", v, 32'h0);
        gen_event(4'hF);
        pop_data(v);   chk("release_data", v, 32'h8001_0000);
        gen_event(4'b1001);
        pop_data(v);   chk("multi_data", v, 32'h8006_0006);
        gen_event(4'hF);
        pop_data(v);   chk("multi_release", v, 32'h8006_0000);
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 4'hD : 4'hF;
            tick(); tick();
        end
        keys = 4'hF;
        repeat (10) tick();
        rd(CADDR, v);  chk("bounce_ctrl", v, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        logic [31:0] exp [4];
        exp[0] = 32'h8001_0001; exp[1] = 32'h8001_0000;
        exp[2] = 32'h8002_0002; exp[3] = 32'h8002_0000;
        gen_event(4'hE); gen_event(4'hF); gen_event(4'hD); gen_event(4'hF);
        gen_event(4'hB);
        rd(CADDR, v);  chk("ovr_ctrl_full", v, 32'h0004_0005);
        for (int i = 0; i < 4; i++) begin
            pop_data(v); chk($sformatf("ovr_data%0d", i), v, exp[i]);
        end
        rd(CADDR, v);  chk("ovr_ctrl_drained", v, 32'h0000_0004);
        wr_ctrl(32'h0000_0004);
        rd(CADDR, v);  chk("ovr_write1_keeps", v, 32'h0000_0004);
        wr_ctrl(32'h0);
        rd(CADDR, v);  chk("ovr_cleared", v, 32'h0);
        gen_event(4'hF);
        pop_data(v);   chk("ovr_key2_release", v, 32'h8004_0000);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        logic [31:0] exp [4];
        exp[0] = 32'h8001_0000; exp[1] = 32'h8002_0002;
        exp[2] = 32'h8002_0000; exp[3] = 32'h8008_0008;
        gen_event(4'hE); gen_event(4'hF); gen_event(4'hD); gen_event(4'hF);
        keys = 4'h7;
        repeat (DB + 1) tick();
        abus = DADDR; we = 1'b0;
        #1 v = dbus;
        chk("fpp_head", v, 32'h8001_0001);
        tick();
        abus = IDLE;
        rd(CADDR, v);  chk("fpp_ctrl", v, 32'h0004_0001);
        for (int i = 0; i < 4; i++) begin
            pop_data(v); chk($sformatf("fpp_data%0d", i), v, exp[i]);
        end
        gen_event(4'hF);
        pop_data(v);   chk("fpp_key3_release", v, 32'h8008_0000);
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        wr_ctrl(32'h0000_0100);
        rd(CADDR, v);  chk("int_ctrl_ie", v, 32'h0000_0100);
        chk("int_idle", {31'd0, intr}, 32'h0);
        gen_event(4'hE);
        chk("int_raised", {31'd0, intr}, 32'h1);
        pop_data(v);   chk("int_data", v, 32'h8001_0001);
        chk("int_cleared", {31'd0, intr}, 32'h0);
        gen_event(4'hF);
        chk("int_raised2", {31'd0, intr}, 32'h1);
        init = 1'b1;
        abus = DADDR;
        tick();
        init = 1'b0; abus = IDLE;
        chk("int_after_init", {31'd0, intr}, 32'h0);
        rd(CADDR, v);  chk("init_ctrl", v, 32'h0);
        rd(DADDR, v);  chk("init_data", v, 32'h0);
    endtask

    initial begin
        init = 1'b1; keys = 4'hF; abus = IDLE; we = 1'b0;
        tb_drv = 1'b0; tb_val = '0;
        test_reset();
        test_press();
        test_bounce();
        test_overrun();
        test_full_push_pop();
        test_interrupt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
